// File: rtl/bcd_serial_add_ctrl.sv
// bcd_serial_add_ctrl: wide packed-BCD adder sequencing one 2-digit slice per clock, LSB pair first
module bcd_serial_add_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                ready,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
    output logic                busy,
    output logic [4*DIGITS-1:0] s,
    output logic                cout,
    output logic                err,
    output logic                res_valid,
    input  logic                res_ack
);
    localparam int KW = $clog2(DIGITS/2 + 1);
    localparam logic [KW-1:0] LAST = KW'(DIGITS/2 - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t st, nxt;
    logic [4*DIGITS-1:0] ra, rb;
    logic [KW-1:0] k;
    logic carry, bad;
    logic [7:0] pa, pb;
    logic [4:0] d0, d1;

    function automatic logic [4:0] dadd(input logic [3:0] x, input logic [3:0] y, input logic c);
        logic [4:0] t;
        t = {1'b0, x} + {1'b0, y} + {4'b0, c};
        return t > 5'd9 ? {1'b1, t[3:0] + 4'd6} : {1'b0, t[3:0]};
    endfunction

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            bad = bad | (a[4*i +: 4] > 4'd9) | (b[4*i +: 4] > 4'd9);
    end

    always_comb begin
        pa = ra[8*k +: 8];
        pb = rb[8*k +: 8];
        d0 = dadd(pa[3:0], pb[3:0], carry);
        d1 = dadd(pa[7:4], pb[7:4], d0[4]);
    end

    always_comb begin
        nxt = st == IDLE ? (start ? RUN : IDLE)
            : st == RUN  ? (k == LAST ? DONE : RUN)
            : (res_ack ? IDLE : DONE);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) st <= IDLE;
        else st <= nxt;

    assign ready     = st == IDLE;
    assign busy      = st == RUN;
    assign res_valid = st == DONE;

    // an invalid operand still walks every pair but never writes s or cout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra    <= '0;
            rb    <= '0;
            carry <= 1'b0;
            k     <= '0;
            s     <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
        end else if (st == IDLE && start) begin
            ra    <= a;
            rb    <= b;
            carry <= cin;
            err   <= bad;
            k     <= '0;
            s     <= '0;
            cout  <= 1'b0;
        end else if (st == RUN) begin
            if (!err) s[8*k +: 8] <= {d1[3:0], d0[3:0]};
            if (k == LAST) cout <= d1[4] & ~err;
            carry <= d1[4];
            k     <= k + 1'b1;
        end
    end
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// tb_bcd_serial_add_ctrl: directed vectors with hand-computed BCD sums and handshake timing
module tb_bcd_serial_add_ctrl;
    localparam int DIGITS = 4;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0, res_ack = 1'b0;
    logic [4*DIGITS-1:0] a = '0, b = '0, s;
    logic ready, busy, cout, err, res_valid;
    int checks = 0, errors = 0;

    bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready), .a(a), .b(b), .cin(cin),
        .busy(busy), .s(s), .cout(cout), .err(err), .res_valid(res_valid), .res_ack(res_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                         input bit ack_in_run, input string tag);
        @(negedge clk);
        check({tag, "_ready"}, ready, 1);
        a = av; b = bv; cin = cv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, busy, 1);
        a = 16'h5555; b = 16'h4444; cin = 1'b1;
        for (int i = 0; i < DIGITS/2 - 1; i++) begin
            res_ack = ack_in_run;
            @(negedge clk);
            res_ack = 1'b0;
            check({tag, "_early"}, res_valid, 0);
        end
        @(negedge clk);
        check({tag, "_valid"}, res_valid, 1);
    endtask

    task automatic finish_op(input logic [15:0] es, input logic ec, input logic ee, input string tag);
        check({tag, "_s"}, s, es);
        check({tag, "_cout"}, cout, ec);
        check({tag, "_err"}, err, ee);
        res_ack = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;
        check({tag, "_idle"}, ready, 1);
        check({tag, "_dropvalid"}, res_valid, 0);
        check({tag, "_held"}, s, es);
    endtask

    initial begin
        #1;
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_valid", res_valid, 0);
        check("rst_s", s, 0);
        check("rst_cout", cout, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;

        do_op(16'h0049, 16'h0049, 1'b0, 1'b0, "t1");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t1_hold_valid", res_valid, 1);
            check("t1_hold_s", s, 16'h0098);
        end
        finish_op(16'h0098, 1'b0, 1'b0, "t1");

        do_op(16'h9999, 16'h0001, 1'b0, 1'b0, "t2a"); finish_op(16'h0000, 1'b1, 1'b0, "t2a");
        do_op(16'h9999, 16'h9999, 1'b1, 1'b0, "t2b"); finish_op(16'h9999, 1'b1, 1'b0, "t2b");
        do_op(16'h0007, 16'h0004, 1'b1, 1'b0, "t2c"); finish_op(16'h0012, 1'b0, 1'b0, "t2c");
        do_op(16'h0091, 16'h0009, 1'b0, 1'b0, "t3a"); finish_op(16'h0100, 1'b0, 1'b0, "t3a");
        do_op(16'h0099, 16'h0001, 1'b0, 1'b0, "t3b"); finish_op(16'h0100, 1'b0, 1'b0, "t3b");
        do_op(16'h00A1, 16'h0001, 1'b0, 1'b0, "t4a"); finish_op(16'h0000, 1'b0, 1'b1, "t4a");
        do_op(16'h0058, 16'h0047, 1'b0, 1'b1, "t4b"); finish_op(16'h0105, 1'b0, 1'b0, "t4b");

        res_ack = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;
        check("t5_ack_idle_ready", ready, 1);
        check("t5_ack_idle_valid", res_valid, 0);

        a = 16'h0012; b = 16'h0034; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        check("t5_hold_busy1", busy, 1);
        repeat (DIGITS/2) @(negedge clk);
        check("t5_hold_valid1", res_valid, 1);
        check("t5_hold_s1", s, 16'h0046);
        res_ack = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;
        check("t5_no_accept_on_ack", ready, 1);
        @(negedge clk);
        check("t5_hold_busy2", busy, 1);
        start = 1'b0;
        repeat (DIGITS/2) @(negedge clk);
        check("t5_hold_valid2", res_valid, 1);
        finish_op(16'h0046, 1'b0, 1'b0, "t5b");

        @(negedge clk);
        a = 16'h9999; b = 16'h0001; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t6_inrun", busy, 1);
        rst = 1'b1;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ready", ready, 1);
        check("t6_rst_valid", res_valid, 0);
        check("t6_rst_s", s, 0);
        check("t6_rst_cout", cout, 0);
        @(negedge clk);
        rst = 1'b0;
        do_op(16'h0011, 16'h0021, 1'b0, 1'b0, "t6b"); finish_op(16'h0032, 1'b0, 1'b0, "t6b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
